// File: rtl/risc_pkg.sv
// Shared fetch-stage definitions: datapath widths, fetch FSM encoding and a NOP
// word used to pre-fill instruction streams.
package risc_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface fetch_unit_if
  import risc_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = INSTR_W
);

  // Handshake: master raises imem_req with imem_addr and holds both unchanged until
  // the cycle in which the slave asserts imem_ack; imem_rdata is valid only in that
  // cycle, and the request is complete at that clock edge.
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {address, instruction} pairs with a registered head that
// keeps its last value when the queue drains or is cleared.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  head_nxt;
  logic          full, empty, do_push, do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Head register is loaded with whatever will sit at the read pointer after this
  // edge, bypassing the array when that slot is being written right now.
  always_comb begin
    do_push    = push && !full && !clear;
    do_pop     = pop && !empty && !clear;
    rd_ptr_nxt = rd_ptr + PW'(do_pop);
    count_nxt  = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (!do_push && do_pop) count_nxt = count - CW'(1);
    head_nxt = head;
    if (count_nxt != '0)
      head_nxt = (do_push && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr + PW'(do_push);
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      head   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads imem at pc_addr, queues returned words for the
// decoder, pulses pc_advance per queued word, and discards work on flush.
module fetch_unit
  import risc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = ADDR_W,
  parameter int DW    = INSTR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [AW-1:0]       pc_addr,
  output logic                pc_advance,
  fetch_unit_if.master        imem,
  input  logic                flush,
  output logic                instr_valid,
  output logic [DW-1:0]       instr,
  output logic [AW-1:0]       instr_addr,
  input  logic                instr_ready,
  output fetch_state_t        state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t  state_nxt;
  logic          req_nxt, adv_nxt, push;
  logic [AW-1:0] addr_nxt;
  logic [CW-1:0] count, credit;
  logic [AW+DW-1:0] head;

  // A slot is reserved for the request in flight so a returning word always fits.
  assign credit = DEPTH_C - count - CW'(state == REQ);

  always_comb begin
    state_nxt = state;
    req_nxt   = imem.imem_req;
    addr_nxt  = imem.imem_addr;
    adv_nxt   = 1'b0;
    push      = 1'b0;
    case (state)
      // While pc_advance is high, pc_addr still shows the word just fetched.
      IDLE: if ((credit != '0) && !flush && !pc_advance) begin
        state_nxt = REQ;
        req_nxt   = 1'b1;
        addr_nxt  = pc_addr;
      end
      REQ: if (imem.imem_ack) begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        if (!flush) begin
          push    = 1'b1;
          adv_nxt = 1'b1;
        end
      end else if (flush) begin
        state_nxt = DROP;
      end
      DROP: if (imem.imem_ack) begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      pc_advance     <= 1'b0;
    end else begin
      state          <= state_nxt;
      imem.imem_req  <= req_nxt;
      imem.imem_addr <= addr_nxt;
      pc_advance     <= adv_nxt;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (instr_ready),
    .clear   (flush),
    .din     ({imem.imem_addr, imem.imem_rdata}),
    .head    (head),
    .valid   (instr_valid),
    .count   (count)
  );

  assign instr_addr = head[AW+DW-1:DW];
  assign instr      = head[DW-1:0];

endmodule
